// File: rtl/iter_shift_logic_unit_if.sv
// Request/result bundle for iter_shift_logic_unit: valid/ready request side, valid/ready result side, busy flag.
// slave = the unit; master = the producer/consumer driving it.
interface iter_shift_logic_unit_if #(
   parameter int WIDTH = 32
);
   localparam int SHAMT_W = $clog2(WIDTH);

   logic               in_valid;
   logic               in_ready;
   logic [2:0]         op;
   logic [WIDTH-1:0]   in1;
   logic [WIDTH-1:0]   in2;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out;
   logic               busy;

   modport slave (
      input  in_valid, op, in1, in2, shamt, out_ready,
      output in_ready, out_valid, out, busy
   );

   modport master (
      output in_valid, op, in1, in2, shamt, out_ready,
      input  in_ready, out_valid, out, busy
   );
endinterface

// File: rtl/iter_shift_logic_unit.sv
// Logic ops in 1 cycle; shifts move <=STEP bits/cycle, L = max(1, ceil(shamt/STEP)); result held until out_ready.
// in_ready drops while shifting or while a result waits; ITER_SHIFT_ROTATE_EN enables op 111 = rotate-left.
module iter_shift_logic_unit #(
   parameter int WIDTH = 32,
   parameter int STEP  = 4
) (
   input logic                    clk,
   input logic                    rst,
   iter_shift_logic_unit_if.slave bus
);
   localparam int SHAMT_W = $clog2(WIDTH);
   localparam logic [SHAMT_W:0] STEP_AMT = (SHAMT_W+1)'(STEP);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   acc_q, acc_d;
   logic [SHAMT_W-1:0] rem_q, rem_d;
   logic [1:0]         kind_q, kind_d;

   logic               accept;
   logic               in_is_shift;
   logic               in_shift_state;
   logic [WIDTH-1:0]   src_val;
   logic [SHAMT_W-1:0] src_rem;
   logic [1:0]         src_kind;
   logic [SHAMT_W:0]   step_amt;
   logic [SHAMT_W-1:0] rem_left;
   logic [WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]   logic_res;

   function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                   input logic [SHAMT_W:0]  a,
                                                   input logic [1:0]        kind);
      logic [2*WIDTH-1:0] dbl;
      logic [WIDTH-1:0]   r;
      dbl = '0;
      r   = '0;
      case (kind)
         2'b00: r = v << a;
         2'b01: r = v >> a;
         2'b10: r = WIDTH'($signed(v) >>> a);
         default: begin
`ifdef ITER_SHIFT_ROTATE_EN
            dbl = {v, v} << a;
            r   = dbl[2*WIDTH-1:WIDTH];
`else
            r   = '0;
`endif
         end
      endcase
      return r;
   endfunction

   assign bus.in_ready  = ~rst & ((state_q == IDLE) | ((state_q == DONE) & bus.out_ready));
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out       = acc_q;
   assign accept        = bus.in_valid & bus.in_ready;

`ifdef ITER_SHIFT_ROTATE_EN
   assign in_is_shift = bus.op[2];
`else
   assign in_is_shift = bus.op[2] & ~(bus.op[1] & bus.op[0]);
`endif

   // One shifter serves both the first step at accept and every later SHIFT step.
   assign in_shift_state = (state_q == SHIFT);
   assign src_val  = in_shift_state ? acc_q  : bus.in2;
   assign src_rem  = in_shift_state ? rem_q  : bus.shamt;
   assign src_kind = in_shift_state ? kind_q : bus.op[1:0];
   assign step_amt = ({1'b0, src_rem} > STEP_AMT) ? STEP_AMT : {1'b0, src_rem};
   assign rem_left = src_rem - step_amt[SHAMT_W-1:0];
   assign shifted  = shift_step(src_val, step_amt, src_kind);

   always_comb begin
      logic_res = '0;
      case (bus.op)
         3'b000:  logic_res = bus.in1 & bus.in2;
         3'b001:  logic_res = bus.in1 | bus.in2;
         3'b010:  logic_res = bus.in1 ^ bus.in2;
         3'b011:  logic_res = ~(bus.in1 | bus.in2);
         default: logic_res = '0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      kind_d  = kind_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               kind_d = bus.op[1:0];
               if (in_is_shift) begin
                  acc_d   = shifted;
                  rem_d   = rem_left;
                  state_d = (rem_left == '0) ? DONE : SHIFT;
               end else begin
                  acc_d   = logic_res;
                  rem_d   = '0;
                  state_d = DONE;
               end
            end else if ((state_q == DONE) && bus.out_ready) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            acc_d = shifted;
            rem_d = rem_left;
            if (rem_left == '0) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         kind_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         kind_q  <= kind_d;
      end
   end
endmodule

// File: tb/tb_iter_shift_logic_unit.sv
// Directed bench for iter_shift_logic_unit (WIDTH=32, STEP=4); op 111 expectations follow ITER_SHIFT_ROTATE_EN.
module tb_iter_shift_logic_unit;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   iter_shift_logic_unit_if #(.WIDTH(32)) bus ();

   iter_shift_logic_unit #(.WIDTH(32), .STEP(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  shamt;
      logic [31:0] exp_out;
      int          exp_lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Cycles from the accept edge until out_valid is seen (1 = next cycle); bounded.
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      bus.op       = v.op;
      bus.in1      = v.in1;
      bus.in2      = v.in2;
      bus.shamt    = v.shamt;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.op       = 3'($urandom);
      bus.in1      = $urandom;
      bus.in2      = $urandom;
      bus.shamt    = 5'($urandom);
      wait_valid(lat);
      chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d_out", idx), bus.out, v.exp_out);
      chk($sformatf("v%0d_busy", idx), 32'(bus.busy), 32'd1);
      tick();
      chk($sformatf("v%0d_idle_valid", idx), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d_idle_busy", idx), 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int lat;
      logic [31:0] held;
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.op        = 3'b000;
      bus.in1       = '0;
      bus.in2       = '0;
      bus.shamt     = '0;

      //               op      in1           in2           sh  expected      L
      vecs.push_back('{3'b000, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h00F000F0, 1});
      vecs.push_back('{3'b011, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0,  32'h000F000F, 1});
      vecs.push_back('{3'b010, 32'hFFFF0000, 32'h0F0F0F0F, 5'd0,  32'hF0F00F0F, 1});
      vecs.push_back('{3'b100, 32'hDEADBEEF, 32'h00000001, 5'd13, 32'h00002000, 4});
      vecs.push_back('{3'b100, 32'hDEADBEEF, 32'h00000001, 5'd0,  32'h00000001, 1});
      vecs.push_back('{3'b110, 32'hDEADBEEF, 32'h80000000, 5'd31, 32'hFFFFFFFF, 8});
      vecs.push_back('{3'b101, 32'hDEADBEEF, 32'h80000000, 5'd31, 32'h00000001, 8});
      vecs.push_back('{3'b100, 32'h12345678, 32'h0000000F, 5'd4,  32'h000000F0, 1});
      vecs.push_back('{3'b110, 32'h0,        32'h7FFFFFFF, 5'd4,  32'h07FFFFFF, 1});
      vecs.push_back('{3'b101, 32'h0,        32'hF0000000, 5'd5,  32'h07800000, 2});
      vecs.push_back('{3'b110, 32'h0,        32'h80000000, 5'd5,  32'hFC000000, 2});
`ifdef ITER_SHIFT_ROTATE_EN
      vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h80000001, 5'd4,  32'h00000018, 1});
      vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h80000001, 5'd31, 32'hC0000000, 8});
`else
      vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h80000001, 5'd4,  32'h00000000, 1});
      vecs.push_back('{3'b111, 32'hFFFFFFFF, 32'h80000001, 5'd31, 32'h00000000, 1});
`endif

      // Reset state
      tick();
      tick();
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out", bus.out, 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
      tick();

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

      // Stall in DONE, then back-to-back accept as the result leaves
      bus.out_ready = 1'b0;
      bus.op = 3'b010; bus.in1 = 32'hAAAA5555; bus.in2 = 32'h0000FFFF; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.in1 = '0; bus.in2 = '0;
      held = 32'hAAAAAAAA;
      for (int c = 0; c < 5; c++) begin
         chk($sformatf("stall%0d_valid", c), 32'(bus.out_valid), 32'd1);
         chk($sformatf("stall%0d_out", c), bus.out, held);
         chk($sformatf("stall%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
         tick();
      end
      bus.out_ready = 1'b1;
      bus.op = 3'b000; bus.in1 = 32'hFF00FF00; bus.in2 = 32'h0F0F0F0F; bus.in_valid = 1'b1;
      #1;
      chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
      tick();
      chk("b2b_valid", 32'(bus.out_valid), 32'd1);
      chk("b2b_out", bus.out, 32'h0F000F00);
      // Second back-to-back request is a shift: out_valid must drop while it runs
      bus.op = 3'b100; bus.in1 = '0; bus.in2 = 32'h00000001; bus.shamt = 5'd8;
      tick();
      bus.in_valid = 1'b0;
      chk("b2b_shift_valid", 32'(bus.out_valid), 32'd0);
      chk("b2b_shift_busy", 32'(bus.busy), 32'd1);
      wait_valid(lat);
      chk("b2b_shift_lat", 32'(lat), 32'd2);
      chk("b2b_shift_out", bus.out, 32'h00000100);
      tick();
      chk("b2b_idle", 32'(bus.busy), 32'd0);

      // Async reset in the middle of a long shift
      bus.op = 3'b100; bus.in2 = 32'h00000003; bus.shamt = 5'd31; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("mid_busy", 32'(bus.busy), 32'd1);
      chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
      chk("mid_valid", 32'(bus.out_valid), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_out", bus.out, 32'd0);
      chk("abort_busy", 32'(bus.busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("abort_stays_idle", 32'(bus.out_valid), 32'd0);
      run_vec('{3'b001, 32'h00001234, 32'h00004321, 5'd0, 32'h00005335, 1}, 99);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
